// File: rtl/spi_mem_pkg.sv
// Shared encodings for the SPI memory slave: frame states and command bytes.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    DISCARD
  } spiStateT;

  localparam logic [7:0] CmdWriteStart = 8'h01;
  localparam logic [7:0] CmdWriteMore  = 8'h02;
  localparam logic [7:0] CmdReadStart  = 8'h03;
  localparam logic [7:0] CmdReadMore   = 8'h04;

endpackage

// File: rtl/spi_mem_slave_if.sv
// Pin and memory-port bundle of the SPI memory slave.
interface spi_mem_slave_if #(
  parameter int AddrBits = 12
);
  logic                SPI_CLK;
  logic                SPI_SS;
  logic                SPI_MOSI;
  logic                SPI_MISO;
  logic [AddrBits-1:0] txMemAddr;
  logic [7:0]          txMemData;
  logic [AddrBits-1:0] rcMemAddr;
  logic [7:0]          rcMemData;
  logic                rcMemWE;
  logic [7:0]          debug_out;

  modport slave (
    input  SPI_CLK, SPI_SS, SPI_MOSI, txMemData,
    output SPI_MISO, txMemAddr, rcMemAddr, rcMemData, rcMemWE, debug_out
  );

  modport master (
    output SPI_CLK, SPI_SS, SPI_MOSI, txMemData,
    input  SPI_MISO, txMemAddr, rcMemAddr, rcMemData, rcMemWE, debug_out
  );
endinterface

// File: rtl/spi_mem_slave_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with edge pulses taken
// from the last two synchronised samples.
module spi_sync #(
  parameter int SyncStages = 2,
  parameter bit IdleLvl    = 1'b0
) (
  input  logic SysClk,
  input  logic Reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SyncStages-1:0] chain;
  logic                  prev;

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      chain <= {SyncStages{IdleLvl}};
      prev  <= IdleLvl;
    end else begin
      chain <= {chain[SyncStages-2:0], din};
      prev  <= chain[SyncStages-1];
    end
  end

  assign level = chain[SyncStages-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
endmodule

// File: rtl/spi_mem_slave.sv
// Mode-0 SPI slave bridging a byte stream to separate receive/transmit memories;
// the first byte of each frame selects write, read or discard.
module spi_mem_slave #(
  parameter int AddrBits   = 12,
  parameter int SyncStages = 2
) (
  input logic            SysClk,
  input logic            Reset,
  spi_mem_slave_if.slave bus
);
  import spi_mem_pkg::*;

  localparam logic [2:0] SyncIdle = 3'b010;  // {MOSI, SS, SCK}

  logic [2:0] pinRaw, pinLvl, pinRise, pinFall;

  assign pinRaw = {bus.SPI_MOSI, bus.SPI_SS, bus.SPI_CLK};

  for (genvar i = 0; i < 3; i++) begin : gSync
    spi_sync #(.SyncStages(SyncStages), .IdleLvl(SyncIdle[i])) uSync (
      .SysClk(SysClk), .Reset(Reset), .din(pinRaw[i]),
      .level(pinLvl[i]), .rise(pinRise[i]), .fall(pinFall[i])
    );
  end

  logic sckRise, sckFall, ssRise, ssFall, ssActive, mosi;
  logic unusedSync;

  assign sckRise = pinRise[0];
  assign sckFall = pinFall[0];
  assign ssRise  = pinRise[1];
  assign ssFall  = pinFall[1];
  assign mosi    = pinLvl[2];
  // SS still counts as active on the cycle its rise shows up, so a byte
  // finishing together with the deselect is still taken.
  assign ssActive   = ~pinLvl[1] | ssRise;
  assign unusedSync = &{pinLvl[0], pinRise[2], pinFall[2]};

  spiStateT            state;
  logic [2:0]          bitCnt;
  logic [7:0]          rxSr, txSr, rxByte;
  logic [AddrBits-1:0] rcAddr, txAddr, rcAddrR;
  logic [7:0]          rcDataR, debugR;
  logic                weR, loadPend, shiftEn, byteDone;

  assign rxByte   = {rxSr[6:0], mosi};
  assign shiftEn  = sckRise & ssActive & (state != IDLE);
  assign byteDone = shiftEn & (bitCnt == 3'd7);

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      rxSr     <= '0;
      txSr     <= '0;
      rcAddr   <= '0;
      txAddr   <= '0;
      loadPend <= 1'b0;
      weR      <= 1'b0;
      rcDataR  <= '0;
      rcAddrR  <= '0;
      debugR   <= '0;
    end else begin
      weR <= 1'b0;
      if (shiftEn) begin
        bitCnt <= bitCnt + 3'd1;
        rxSr   <= rxByte;
      end
      if (sckFall) loadPend <= 1'b0;
      if (byteDone) begin
        debugR   <= rxByte;
        loadPend <= 1'b1;
        case (state)
          CMD:
            case (rxByte)
              CmdWriteStart: begin rcAddr <= '0; state <= WRITE; end
              CmdWriteMore:  state <= WRITE;
              CmdReadStart:  begin txAddr <= '0; state <= READ; end
              CmdReadMore:   state <= READ;
              default:       state <= DISCARD;
            endcase
          WRITE: begin
            weR     <= 1'b1;
            rcDataR <= rxByte;
            rcAddrR <= rcAddr;
            rcAddr  <= rcAddr + AddrBits'(1);
          end
          default: ;
        endcase
      end
      // The fall right after a completed byte reloads from memory; the memory
      // address was presented many cycles earlier, so txMemData is settled.
      if (sckFall && state == READ) begin
        if (loadPend) begin
          txSr   <= bus.txMemData;
          txAddr <= txAddr + AddrBits'(1);
        end else begin
          txSr <= {txSr[6:0], 1'b0};
        end
      end
      if (state == IDLE && ssFall) begin
        state    <= CMD;
        bitCnt   <= '0;
        loadPend <= 1'b0;
      end
      if (ssRise) state <= IDLE;
    end
  end

  assign bus.SPI_MISO  = (state == READ) & txSr[7];
  assign bus.txMemAddr = txAddr;
  assign bus.rcMemAddr = rcAddrR;
  assign bus.rcMemData = rcDataR;
  assign bus.rcMemWE   = weR;
  assign bus.debug_out = debugR;
endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: directed frames plus random frames checked against
// a byte-level model of the command protocol.
module tb_spi_mem_slave;
  localparam int AB   = 4;
  localparam int HALF = 4;  // SysClk cycles per SCK half period
  localparam int MEMN = 1 << AB;

  typedef struct packed {
    logic [AB-1:0] a;
    logic [7:0]    d;
  } wrT;

  logic SysClk = 1'b0;
  logic Reset;
  always #5 SysClk = ~SysClk;

  spi_mem_slave_if #(.AddrBits(AB)) bus ();
  spi_mem_slave #(.AddrBits(AB), .SyncStages(2)) dut (
    .SysClk(SysClk), .Reset(Reset), .bus(bus)
  );

  logic [7:0] txMem[MEMN];
  always @(posedge SysClk) bus.txMemData <= txMem[bus.txMemAddr];

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Protocol model state
  int         mMode;  // 0 none, 1 write, 2 read, 3 discard
  int         mRc = 0;
  int         mTx = 0;
  logic [7:0] mDebug = 8'h00;
  wrT         expWr[$];
  wrT         wrLog[$];
  logic [7:0] txnBytes[32];
  logic [7:0] rxMiso[32];
  logic       sawTx2 = 1'b0;
  wrT         w;

  always @(posedge SysClk) begin
    #1;
    if (bus.txMemAddr == AB'(2)) sawTx2 = 1'b1;
    if (!Reset && bus.rcMemWE === 1'b1) begin
      wrLog.push_back(wrT'{a: bus.rcMemAddr, d: bus.rcMemData});
      if (expWr.size() == 0) check("rcMemWE spurious", bus.rcMemWE, 1'b0);
      else begin
        w = expWr.pop_front();
        check("rcMemAddr", bus.rcMemAddr, w.a);
        check("rcMemData", bus.rcMemData, w.d);
      end
    end
  end

  task automatic sckHalf();
    repeat (HALF) @(negedge SysClk);
  endtask

  task automatic checkResetVals();
    check("reset rcMemWE", bus.rcMemWE, 1'b0);
    check("reset rcMemData", bus.rcMemData, 8'h00);
    check("reset SPI_MISO", bus.SPI_MISO, 1'b0);
    check("reset debug_out", bus.debug_out, 8'h00);
    check("reset txMemAddr", bus.txMemAddr, 0);
  endtask

  // One frame: nBytes whole bytes then extraBits of txnBytes[nBytes].
  // fastEnd raises SS together with the final SCK rise.
  task automatic runTxn(input int nBytes, input int extraBits, input bit fastEnd, input bit leaveOpen);
    logic [7:0] expMiso[32];
    int total, loads, bi, bp;
    mMode = 0;
    for (int i = 0; i < nBytes; i++) begin
      mDebug = txnBytes[i];
      if (i == 0) begin
        case (txnBytes[0])
          8'h01:   begin mMode = 1; mRc = 0; end
          8'h02:   mMode = 1;
          8'h03:   begin mMode = 2; mTx = 0; end
          8'h04:   mMode = 2;
          default: mMode = 3;
        endcase
      end else if (mMode == 1) begin
        expWr.push_back(wrT'{a: AB'(mRc), d: txnBytes[i]});
        mRc = (mRc + 1) % MEMN;
      end
    end
    if (mMode == 2) begin
      // Byte i on MISO comes from the memory word loaded after byte i-1 completed.
      for (int i = 1; i <= nBytes; i++) expMiso[i] = txMem[(mTx + i - 1) % MEMN];
      loads = (fastEnd && extraBits == 0) ? nBytes - 1 : nBytes;
      mTx = (mTx + loads) % MEMN;
    end

    total = nBytes * 8 + extraBits;
    @(negedge SysClk);
    bus.SPI_SS = 1'b0;
    sckHalf();
    for (int k = 0; k < total; k++) begin
      bi = k / 8;
      bp = 7 - (k % 8);
      bus.SPI_MOSI = txnBytes[bi][bp];
      sckHalf();
      rxMiso[bi][bp] = bus.SPI_MISO;
      if (bi > 0) check("SPI_MISO bit", bus.SPI_MISO, (mMode == 2) ? expMiso[bi][bp] : 1'b0);
      if (fastEnd && k == total - 1) bus.SPI_SS = 1'b1;
      bus.SPI_CLK = 1'b1;
      sckHalf();
      bus.SPI_CLK = 1'b0;
    end
    sckHalf();
    if (!leaveOpen) begin
      bus.SPI_SS = 1'b1;
      repeat (8) @(negedge SysClk);
      check("writes outstanding", expWr.size(), 0);
      check("debug_out", bus.debug_out, mDebug);
      check("txMemAddr", bus.txMemAddr, mTx);
      repeat (2 * HALF) @(negedge SysClk);
    end
  endtask

  int base, nb, eb, sel;
  bit fe;

  initial begin
    Reset = 1'b1;
    bus.SPI_CLK = 1'b0;
    bus.SPI_SS = 1'b1;
    bus.SPI_MOSI = 1'b0;
    for (int i = 0; i < MEMN; i++) txMem[i] = 8'($urandom);
    txMem[0] = 8'h81;
    txMem[1] = 8'h42;
    repeat (4) @(negedge SysClk);
    checkResetVals();
    Reset = 1'b0;
    repeat (4) @(negedge SysClk);

    // Write start, two payload bytes
    base = wrLog.size();
    txnBytes[0] = 8'h01; txnBytes[1] = 8'hA5; txnBytes[2] = 8'h3C;
    runTxn(3, 0, 0, 0);
    check("wr start count", wrLog.size() - base, 2);
    check("wr start first", {wrLog[base].a, wrLog[base].d}, {4'd0, 8'hA5});
    check("wr start second", {wrLog[base+1].a, wrLog[base+1].d}, {4'd1, 8'h3C});
    check("wr start debug", bus.debug_out, 8'h3C);

    // Write continue
    base = wrLog.size();
    txnBytes[0] = 8'h02; txnBytes[1] = 8'h77;
    runTxn(2, 0, 0, 0);
    check("wr more", {wrLog[base].a, wrLog[base].d}, {4'd2, 8'h77});

    // Read start
    sawTx2 = 1'b0;
    txnBytes[0] = 8'h03; txnBytes[1] = 8'h00; txnBytes[2] = 8'h00;
    runTxn(3, 0, 0, 0);
    check("rd byte 1", rxMiso[1], 8'h81);
    check("rd byte 2", rxMiso[2], 8'h42);
    check("txMemAddr reached 2", sawTx2, 1'b1);

    // Unknown command discards the frame
    base = wrLog.size();
    txnBytes[0] = 8'h55; txnBytes[1] = 8'h11;
    runTxn(2, 0, 0, 0);
    check("discard writes", wrLog.size() - base, 0);
    check("discard debug", bus.debug_out, 8'h11);

    // Partial byte dropped
    base = wrLog.size();
    txnBytes[0] = 8'h01; txnBytes[1] = 8'hFF;
    runTxn(1, 4, 0, 0);
    check("partial writes", wrLog.size() - base, 0);
    check("partial debug", bus.debug_out, 8'h01);

    // Address wrap: 17 payload bytes, last lands at 0
    base = wrLog.size();
    txnBytes[0] = 8'h01;
    for (int i = 1; i <= 17; i++) txnBytes[i] = 8'($urandom);
    runTxn(18, 0, 0, 0);
    check("wrap count", wrLog.size() - base, 17);
    check("wrap addr", wrLog[base+16].a, 4'd0);
    check("wrap data", wrLog[base+16].d, txnBytes[17]);

    // Byte completion coinciding with deselect
    base = wrLog.size();
    txnBytes[0] = 8'h01; txnBytes[1] = 8'h9E;
    runTxn(2, 0, 1, 0);
    check("fast end write", {wrLog[base].a, wrLog[base].d}, {4'd0, 8'h9E});

    for (int t = 0; t < 30; t++) begin
      nb = $urandom_range(1, 6);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      fe = (nb >= 2) && ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 4);
      case (sel)
        0: txnBytes[0] = 8'h01;
        1: txnBytes[0] = 8'h02;
        2: txnBytes[0] = 8'h03;
        3: txnBytes[0] = 8'h04;
        default: txnBytes[0] = 8'($urandom_range(5, 255));
      endcase
      for (int i = 1; i < 8; i++) txnBytes[i] = 8'($urandom);
      runTxn(nb, eb, fe, 0);
    end

    // Reset three bits into a write payload byte
    txnBytes[0] = 8'h01; txnBytes[1] = 8'hF0;
    runTxn(1, 3, 0, 1);
    Reset = 1'b1;
    @(negedge SysClk);
    checkResetVals();
    bus.SPI_SS = 1'b1;
    repeat (4) @(negedge SysClk);
    Reset = 1'b0;
    mRc = 0; mTx = 0; mDebug = 8'h00;
    expWr.delete();
    repeat (4) @(negedge SysClk);
    check("post reset debug", bus.debug_out, 8'h00);
    base = wrLog.size();
    txnBytes[0] = 8'h02; txnBytes[1] = 8'h5A;
    runTxn(2, 0, 0, 0);
    check("post reset write", {wrLog[base].a, wrLog[base].d}, {4'd0, 8'h5A});

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/spi_mem_slave.md
SPI_MEM_SLAVE -- requirements
Module: spi_mem_slave

Interface
REQ-001 SHALL have parameter AddrBits, default 12, width of rcMemAddr/txMemAddr and both byte pointers.
REQ-002 SHALL have parameter SyncStages, default 2, flop count of each input synchroniser (minimum 2).
REQ-003 SysClk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on SysClk.
REQ-005 SPI_CLK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to SysClk.
REQ-006 SPI_SS  in  1  active-low slave select, asynchronous.
REQ-007 SPI_MOSI  in  1  master-to-slave data, MSB first, asynchronous.
REQ-008 SPI_MISO  out  1  slave-to-master data, MSB first.
REQ-009 txMemAddr  out  AddrBits  transmit-memory read address.
REQ-010 txMemData  in  8  transmit-memory read data, valid one SysClk after txMemAddr.
REQ-011 rcMemAddr  out  AddrBits  receive-memory write address.
REQ-012 rcMemData  out  8  receive-memory write data.
REQ-013 rcMemWE  out  1  receive-memory write strobe, one SysClk wide.
REQ-014 debug_out  out  8  last complete byte received.

Function
REQ-015 SPI_CLK, SPI_SS and SPI_MOSI SHALL each pass through a SyncStages-deep synchroniser; SCK rise/fall SHALL be detected from the last two synchronised samples.
REQ-016 Operation SHALL be guaranteed for SPI_CLK frequency <= SysClk/8.
REQ-017 On each SCK rise with SS low, MOSI SHALL shift into an 8-bit register and a 3-bit bit counter SHALL increment; the 8th bit completes a byte.
REQ-018 States: IDLE, CMD, WRITE, READ, DISCARD.
REQ-019 IDLE -> CMD on synchronised SS falling edge; bit counter cleared.
REQ-020 CMD byte decode: 0x01 WRITE_START (rcAddr<=0, ->WRITE); 0x02 WRITE_MORE (rcAddr kept, ->WRITE); 0x03 READ_START (txAddr<=0, ->READ); 0x04 READ_MORE (txAddr kept, ->READ); any other value -> DISCARD.
REQ-021 WRITE: each completed byte SHALL drive rcMemData=byte, rcMemAddr=rcAddr, rcMemWE=1 for exactly one SysClk, then rcAddr increments.
REQ-022 READ: txMemAddr SHALL equal txAddr; on the first SCK fall after a byte-completing rise, the MISO shift register SHALL load txMemData and txAddr SHALL increment; on other SCK falls it SHALL shift left by one.
REQ-023 The first read data byte SHALL be the byte following the command byte; data on MISO SHALL be undefined only during the command byte itself.
REQ-024 SPI_MISO SHALL equal shift-register bit 7 in READ, otherwise 0.
REQ-025 DISCARD: received bytes SHALL update debug_out only; no writes, MISO 0.
REQ-026 rcAddr and txAddr SHALL wrap from 2^AddrBits-1 to 0 without error.
REQ-027 Synchronised SS rising edge in any state SHALL return to IDLE; a partial byte SHALL be dropped (no write, debug_out unchanged); rcAddr/txAddr SHALL persist for *_MORE commands.
REQ-028 A byte completion and SS rise in the same SysClk SHALL complete the byte (write issued) before returning to IDLE.
REQ-029 debug_out SHALL update on every completed byte in every state, including the command byte.

Reset
REQ-030 Reset SHALL force state IDLE, rcAddr=0, txAddr=0, bit counter 0, shift registers 0, rcMemWE=0, rcMemData=0, SPI_MISO=0, debug_out=0x00, synchronisers to idle levels (SCK 0, SS 1).
REQ-031 Reset asserted mid-transfer SHALL abort it; the block SHALL ignore the bus until the next SS falling edge.

Structure
REQ-032 Command codes (0x01-0x04) and the state enumeration SHALL reside in shared package spi_mem_pkg.
REQ-033 Synchroniser plus edge detector SHALL be sub-module spi_sync (parameter SyncStages; outputs level, rise, fall), instantiated three times.

Verification
REQ-034 SS low, send 0x01,0xA5,0x3C, SS high -> writes (0,0xA5),(1,0x3C), each rcMemWE one cycle; debug_out=0x3C.
REQ-035 Then SS low, send 0x02,0x77 -> write (2,0x77).
REQ-036 txMem[0..1]=0x81,0x42; send 0x03,0x00,0x00 -> MISO bytes 0x81,0x42 after command; txMemAddr reaches 2.
REQ-037 Send 0x55,0x11 -> DISCARD, no rcMemWE, MISO 0, debug_out=0x11.
REQ-038 Send 0x01 plus 4 bits, SS high -> no write, debug_out=0x01; AddrBits=4, 17 WRITE_START bytes -> 17th byte at address 0.
REQ-039 Reset after 3 bits of a WRITE payload byte -> all REQ-030 values next cycle; next transfer decodes command normally.
